// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared filter taps, rounding constants and FSM states for the sub-pel interpolators
package interp_pkg;

  localparam int NTAPS       = 8;
  localparam int CENTER      = 3;
  localparam int ROUND_ADD   = 32;
  localparam int ROUND_SHIFT = 6;

  localparam int COEF_A [NTAPS] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int COEF_B [NTAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int COEF_C [NTAPS] = '{0, 1, -5, 17, 58, -10, 4, -1};

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} interp_state_e;

endpackage

// File: rtl/interp_taps.sv
// rtl/interp_taps.sv - combinational 8-tap quarter/half/three-quarter filter sums
module interp_taps import interp_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int SUM_W = PIX_W + 9
) (
  input  logic [NTAPS-1:0][PIX_W-1:0] taps_i,
  output logic signed [SUM_W-1:0]     sum_a_o,
  output logic signed [SUM_W-1:0]     sum_b_o,
  output logic signed [SUM_W-1:0]     sum_c_o
);

  int acc_a;
  int acc_b;
  int acc_c;

  always_comb begin
    acc_a = 0;
    acc_b = 0;
    acc_c = 0;
    for (int i = 0; i < NTAPS; i++) begin
      acc_a += COEF_A[i] * int'(taps_i[i]);
      acc_b += COEF_B[i] * int'(taps_i[i]);
      acc_c += COEF_C[i] * int'(taps_i[i]);
    end
    sum_a_o = SUM_W'(acc_a);
    sum_b_o = SUM_W'(acc_b);
    sum_c_o = SUM_W'(acc_c);
  end

endmodule

// File: rtl/subpel_line_interpolator.sv
// rtl/subpel_line_interpolator.sv - streaming 1-D sub-pel interpolator over one line with edge replication
module subpel_line_interpolator import interp_pkg::*; #(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 16,
  parameter int OUT_W  = 17
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_full,
  output logic signed [OUT_W-1:0] out_a,
  output logic signed [OUT_W-1:0] out_b,
  output logic signed [OUT_W-1:0] out_c,
  output logic                    out_last
);

  localparam int SUM_W = PIX_W + 9;
  localparam int CNT_W = $clog2(LINE_W + 4);
  localparam logic [CNT_W-1:0] FIRST_RES = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_RES  = CNT_W'(LINE_W + 3);
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(LINE_W - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  interp_state_e state_q, state_d;
  logic [NTAPS-1:0][PIX_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, adv_cnt_q, adv_cnt_d;
  logic [2:0] pad_cnt_q, pad_cnt_d;
  logic mode_q, mode_d;
  logic win_ok_q, win_ok_d, win_last_q, win_last_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [PIX_W-1:0] full_q, full_d;
  logic signed [OUT_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [SUM_W-1:0] sum_a, sum_b, sum_c;
  logic stall, accept, pad, adv;

  function automatic logic signed [OUT_W-1:0] fmt(input logic signed [SUM_W-1:0] s, input logic raw);
    logic signed [SUM_W-1:0] r;
    r = (s + SUM_W'(ROUND_ADD)) >>> ROUND_SHIFT;
    if (raw)            return OUT_W'(s);
    if (r[SUM_W-1])     return '0;
    if (r > PIX_MAX)    return OUT_W'(PIX_MAX);
    return OUT_W'(r);
  endfunction

  interp_taps #(.PIX_W(PIX_W), .SUM_W(SUM_W)) u_taps (
    .taps_i  (win_q),
    .sum_a_o (sum_a),
    .sum_b_o (sum_b),
    .sum_c_o (sum_c)
  );

  // A pending unaccepted result freezes the whole pipeline, including pad injection.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !reset && !stall && (state_q != FLUSH);
  assign accept   = in_valid && in_ready;
  assign pad      = (state_q == FLUSH) && !stall && (pad_cnt_q != 3'd4);
  assign adv      = accept || pad;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    pix_cnt_d   = pix_cnt_q;
    adv_cnt_d   = adv_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    mode_d      = mode_q;
    win_ok_d    = win_ok_q;
    win_last_d  = win_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    full_d      = full_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;

    if (adv) begin
      if (state_q == IDLE) begin
        // Whole window takes p0; after four more shifts w[0..3] still hold p0.
        win_d     = {NTAPS{in_pix}};
        adv_cnt_d = '0;
        pix_cnt_d = CNT_W'(1);
        pad_cnt_d = '0;
        mode_d    = mode;
        state_d   = FILL;
      end else begin
        win_d     = {(accept ? in_pix : win_q[NTAPS-1]), win_q[NTAPS-1:1]};
        adv_cnt_d = adv_cnt_q + 1'b1;
        if (accept) pix_cnt_d = pix_cnt_q + 1'b1;
        if (pad)    pad_cnt_d = pad_cnt_q + 1'b1;
        if (accept && (pix_cnt_q == LAST_PIX))
          state_d = FLUSH;
        else if ((state_q == FILL) && (adv_cnt_d == FIRST_RES))
          state_d = STREAM;
      end
    end

    if ((state_q == FLUSH) && (pad_cnt_q == 3'd4) && out_valid_q && out_last_q && out_ready)
      state_d = IDLE;

    if (!stall) begin
      win_ok_d    = adv && (state_q != IDLE) && (adv_cnt_d >= FIRST_RES);
      win_last_d  = adv && (state_q != IDLE) && (adv_cnt_d == LAST_RES);
      out_valid_d = win_ok_q;
      out_last_d  = win_ok_q && win_last_q;
      if (win_ok_q) begin
        full_d = win_q[CENTER];
        a_d    = fmt(sum_a, mode_q);
        b_d    = fmt(sum_b, mode_q);
        c_d    = fmt(sum_c, mode_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      pix_cnt_q   <= '0;
      adv_cnt_q   <= '0;
      pad_cnt_q   <= '0;
      mode_q      <= 1'b0;
      win_ok_q    <= 1'b0;
      win_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      full_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      pix_cnt_q   <= pix_cnt_d;
      adv_cnt_q   <= adv_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      mode_q      <= mode_d;
      win_ok_q    <= win_ok_d;
      win_last_q  <= win_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      full_q      <= full_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_full  = full_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;

endmodule
